// File: rtl/fadd_4.sv
`default_nettype none
// ============================================================================
// Module   : fadd_4
// Purpose  : Registered WIDTH-bit ripple-carry adder. Computes
//            {cout,sum} = in1 + in2 + cin through a chain of one-bit full
//            adders and registers the result together with a two's-complement
//            overflow flag and a one-cycle output strobe.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous, active-high reset
//            in_valid  - qualifies in1/in2/cin this cycle
//            in1, in2  - WIDTH-bit operands
//            cin       - carry-in (weight 1)
//            sum       - registered low WIDTH bits of the result
//            cout      - registered carry-out (bit WIDTH of the result)
//            ovf       - registered signed overflow (carry into MSB ^ carry out)
//            out_valid - high for one cycle when a new result is presented
// Revision : 1.0 - initial release
// ============================================================================
module fadd_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // Carry chain: w_c[0] is the carry-in, w_c[WIDTH] is the carry-out.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic w_p;
      assign w_p      = in1[i] ^ in2[i];
      assign w_s[i]   = w_p ^ w_c[i];
      assign w_c[i+1] = (in1[i] & in2[i]) | (w_c[i] & w_p);
    end
  endgenerate

  // With WIDTH=1 this naturally becomes c_1 ^ cin because w_c[0] is cin.
  logic w_ovf;
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             valid_q, valid_d;

  // Idle cycles keep the last result visible; only the strobe drops.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = w_s;
      cout_d  = w_c[WIDTH];
      ovf_d   = w_ovf;
      valid_d = 1'b1;
    end
  end

  // Reset wins over in_valid on the same edge; that input is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fadd_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_4
// Purpose  : Self-checking bench for fadd_4 at WIDTH=4 and WIDTH=8 against an
//            arithmetic reference model (integer add, signed range test).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fadd_4;

  logic       clk = 1'b0;
  logic       rst;

  logic       v4, c4;
  logic [3:0] a4, b4;
  logic [3:0] sum4;
  logic       cout4, ovf4, ov4;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] sum8;
  logic       cout8, ovf8, ov8;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected register contents, kept by the model.
  int e_sum4, e_cout4, e_ovf4, e_ov4;
  int e_sum8, e_cout8, e_ovf8, e_ov8;

  always #5 clk = ~clk;

  fadd_4 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in1(a4), .in2(b4), .cin(c4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .out_valid(ov4)
  );

  fadd_4 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in1(a8), .in2(b8), .cin(c8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
  );

  // Reference: full-width integer sum, signed overflow from range test.
  function automatic int ref_sum(int a, int b, int c, int w);
    return (a + b + c) % (1 << w);
  endfunction

  function automatic int ref_cout(int a, int b, int c, int w);
    return ((a + b + c) >= (1 << w)) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(int a, int b, int c, int w);
    int sa, sb, r;
    sa = (a >= (1 << (w-1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w-1))) ? b - (1 << w) : b;
    r  = sa + sb + c;
    return (r > (1 << (w-1)) - 1 || r < -(1 << (w-1))) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag);
    chk({tag, ".sum4"},  int'(sum4),  e_sum4);
    chk({tag, ".cout4"}, int'(cout4), e_cout4);
    chk({tag, ".ovf4"},  int'(ovf4),  e_ovf4);
    chk({tag, ".ov4"},   int'(ov4),   e_ov4);
  endtask

  task automatic check8(input string tag);
    chk({tag, ".sum8"},  int'(sum8),  e_sum8);
    chk({tag, ".cout8"}, int'(cout8), e_cout8);
    chk({tag, ".ovf8"},  int'(ovf8),  e_ovf8);
    chk({tag, ".ov8"},   int'(ov8),   e_ov8);
  endtask

  // Apply one cycle to both instances, update the model, then compare.
  task automatic step(input logic va, input int a, input int b, input int c,
                      input logic vb, input int x, input int y, input int z,
                      input string tag);
    v4 = va; a4 = 4'(a); b4 = 4'(b); c4 = 1'(c);
    v8 = vb; a8 = 8'(x); b8 = 8'(y); c8 = 1'(z);
    @(posedge clk);
    #1;
    if (va) begin
      e_sum4 = ref_sum(a, b, c, 4); e_cout4 = ref_cout(a, b, c, 4);
      e_ovf4 = ref_ovf(a, b, c, 4);
    end
    e_ov4 = va ? 1 : 0;
    if (vb) begin
      e_sum8 = ref_sum(x, y, z, 8); e_cout8 = ref_cout(x, y, z, 8);
      e_ovf8 = ref_ovf(x, y, z, 8);
    end
    e_ov8 = vb ? 1 : 0;
    check4(tag);
    check8(tag);
  endtask

  task automatic step4(input int a, input int b, input int c, input string tag);
    step(1'b1, a, b, c, 1'b0, 0, 0, 0, tag);
  endtask

  task automatic step8(input int x, input int y, input int z, input string tag);
    step(1'b0, 0, 0, 0, 1'b1, x, y, z, tag);
  endtask

  initial begin
    rst = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    e_sum4 = 0; e_cout4 = 0; e_ovf4 = 0; e_ov4 = 0;
    e_sum8 = 0; e_cout8 = 0; e_ovf8 = 0; e_ov8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check4("reset");
    check8("reset");
    rst = 1'b0;

    // Exhaustive WIDTH=4, back-to-back.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          step4(a, b, c, "exh");

    // Boundaries and signed overflow, against literal results.
    step4(0, 0, 0, "b000");
    chk("b000.sum", int'(sum4), 0);  chk("b000.cout", int'(cout4), 0);
    chk("b000.ovf", int'(ovf4), 0);
    step4(15, 15, 1, "b15151");
    chk("b15151.sum", int'(sum4), 15); chk("b15151.cout", int'(cout4), 1);
    chk("b15151.ovf", int'(ovf4), 0);
    step4(15, 1, 0, "b1510");
    chk("b1510.sum", int'(sum4), 0); chk("b1510.cout", int'(cout4), 1);
    chk("b1510.ovf", int'(ovf4), 0);
    step4(7, 1, 0, "o710");
    chk("o710.sum", int'(sum4), 8); chk("o710.cout", int'(cout4), 0);
    chk("o710.ovf", int'(ovf4), 1);
    step4(8, 8, 0, "o880");
    chk("o880.sum", int'(sum4), 0); chk("o880.cout", int'(cout4), 1);
    chk("o880.ovf", int'(ovf4), 1);
    step4(8, 7, 1, "o871");
    chk("o871.sum", int'(sum4), 0); chk("o871.cout", int'(cout4), 1);
    chk("o871.ovf", int'(ovf4), 0);

    // Hold: result stays, strobe drops.
    step4(3, 4, 0, "hold0");
    chk("hold0.sum", int'(sum4), 7); chk("hold0.ov", int'(ov4), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 9, 9, 0, 1'b0, 0, 0, 0, "hold");
      chk("hold.sum", int'(sum4), 7); chk("hold.cout", int'(cout4), 0);
      chk("hold.ov", int'(ov4), 0);
    end

    // Reset on the same edge as a valid input: input discarded.
    v4 = 1'b1; a4 = 4'd15; b4 = 4'd15; c4 = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    e_sum4 = 0; e_cout4 = 0; e_ovf4 = 0; e_ov4 = 0;
    e_sum8 = 0; e_cout8 = 0; e_ovf8 = 0; e_ov8 = 0;
    check4("rstv");
    check8("rstv");
    rst = 1'b0;
    step4(2, 2, 1, "post_rst");
    chk("post_rst.sum", int'(sum4), 5);

    // WIDTH=8 parameter cases.
    step8(255, 1, 0, "w8a");
    chk("w8a.sum", int'(sum8), 0); chk("w8a.cout", int'(cout8), 1);
    chk("w8a.ovf", int'(ovf8), 0);
    step8(127, 1, 0, "w8b");
    chk("w8b.sum", int'(sum8), 128); chk("w8b.ovf", int'(ovf8), 1);

    // Random traffic on both widths with random valid gaps.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fadd_4.md
Name: fadd_4

Overview:
- Registered WIDTH-bit ripple-carry adder (default 4 bits): sum = in1 + in2 + cin, plus carry-out and signed-overflow flag.
- Datapath is a chain of WIDTH one-bit full-adder cells. A single output register stage follows the chain.
- Used as a leaf arithmetic block wherever a small clocked adder with carry-in/carry-out is needed. Cascadable through cin/cout.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in1/in2/cin for the current cycle.
- in1  input  WIDTH  unsigned operand A.
- in2  input  WIDTH  unsigned operand B.
- cin  input  1  carry-in, weight 1.
- sum  output  WIDTH  registered low WIDTH bits of in1+in2+cin.
- cout  output  1  registered carry-out, bit WIDTH of the full result.
- ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for one cycle when sum/cout/ovf hold a newly computed result.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high: on a rising clk edge with rst=1, sum=0, cout=0, ovf=0, out_valid=0.
- Reset priority: rst overrides in_valid on the same edge. The input sampled on that edge is discarded and produces no result.
- Arithmetic: compute the full WIDTH+1-bit result {cout,sum} = in1 + in2 + cin. No saturation; wrap-around modulo 2^WIDTH is expected.
- Structure: bit i is a full adder.
  - s_i = a_i ^ b_i ^ c_i
  - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = cin; cout = c_WIDTH.
- Overflow: ovf = c_WIDTH ^ c_(WIDTH-1). For WIDTH=1, ovf = c_1 ^ cin.
- Latency: exactly 1 cycle. Operands sampled with in_valid=1 on edge N appear on sum/cout/ovf after edge N, with out_valid=1 for that cycle.
- Throughput: one operation per cycle; back-to-back in_valid is supported.
- Idle cycles: on an edge with in_valid=0 and rst=0, sum/cout/ovf hold their previous values and out_valid goes to 0.
- Inputs are not otherwise registered. The combinational path runs from the inputs through the carry chain to the output register only.
- No X-propagation handling is required beyond standard simulation semantics.

Test Plan:
- Exhaustive (WIDTH=4): every cin in {0,1}, in1 in 0..15, in2 in 0..15, in_valid=1 back-to-back (512 vectors). Each result, one cycle later, must satisfy {cout,sum} == in1+in2+cin, with out_valid=1.
- Boundaries:
  - 0+0+0 -> sum=0, cout=0, ovf=0.
  - 15+15+1 -> sum=15, cout=1, ovf=0.
  - 15+1+0 -> sum=0, cout=1, ovf=0.
- Signed overflow:
  - 7+1+0 -> sum=8, cout=0, ovf=1.
  - 8+8+0 -> sum=0, cout=1, ovf=1.
  - 8+7+1 -> sum=0, cout=1, ovf=0.
- Hold: apply 3+4+0 with in_valid=1, then in_valid=0 with in1=9, in2=9 for 3 cycles -> sum stays 7, cout=0, out_valid=1 then 0,0,0.
- Reset: assert rst on the same edge as in_valid=1 with 15+15+1 -> after the edge sum=0, cout=0, ovf=0, out_valid=0. Deassert, apply 2+2+1 -> sum=5 one cycle later.
- Parameter: WIDTH=8 with 255+1+0 -> sum=0, cout=1, ovf=0; 127+1+0 -> sum=128, ovf=1.
